// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, data port, memory side and stall/error outputs.
// slave = arbiter view, master = environment (pipeline stages + memory) view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic [DATA_W-1:0]     if_rdata;
    logic                  if_ack;
    logic                  d_req;
    logic                  d_we;
    logic [DATA_W/8-1:0]   d_sel;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W-1:0]     d_rdata;
    logic                  d_ack;
    logic                  m_en;
    logic                  m_we;
    logic [DATA_W/8-1:0]   m_sel;
    logic [ADDR_W-1:0]     m_addr;
    logic [DATA_W-1:0]     m_wdata;
    logic [DATA_W-1:0]     m_rdata;
    logic                  m_ready;
    logic                  stallreq_if;
    logic                  stallreq_mem;
    logic                  bus_err;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_sel, d_addr, d_wdata, m_rdata, m_ready,
        output if_rdata, if_ack, d_rdata, d_ack, m_en, m_we, m_sel, m_addr, m_wdata,
               stallreq_if, stallreq_mem, bus_err
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_sel, d_addr, d_wdata, m_rdata, m_ready,
        input  if_rdata, if_ack, d_rdata, d_ack, m_en, m_we, m_sel, m_addr, m_wdata,
               stallreq_if, stallreq_mem, bus_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data ports (alternating priority).
// Optional wait timeout with bus_err pulse when MEMARB_TIMEOUT_EN is defined.
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic          clk,
    input  logic          resetn,
    mem_arbiter_if.slave  bus
);
    localparam int SEL_W = DATA_W / 8;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;
    localparam logic [1:0] ACK    = 2'd3;

    logic [1:0]        state;
    logic              last_d;
    logic              m_en;
    logic              m_we;
    logic [SEL_W-1:0]  m_sel;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] if_rdata;
    logic [DATA_W-1:0] d_rdata;
    logic              if_ack;
    logic              d_ack;
    logic              bus_err;
    logic              busy;
    logic              timeout_hit;
    logic              grant_d;

    assign busy    = (state == BUSY_I) || (state == BUSY_D);
    // Data wins unless fetch is also pending and data had the previous grant.
    assign grant_d = bus.d_req && (!bus.if_req || !last_d);

`ifdef MEMARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] wait_cnt;

    assign timeout_hit = busy && !bus.m_ready && (wait_cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt <= '0;
            bus_err  <= 1'b0;
        end else begin
            bus_err <= timeout_hit;
            if (!busy)
                wait_cnt <= '0;
            else if (!bus.m_ready)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            last_d   <= 1'b0;
            m_en     <= 1'b0;
            m_we     <= 1'b0;
            m_sel    <= '0;
            m_addr   <= '0;
            m_wdata  <= '0;
            if_rdata <= '0;
            d_rdata  <= '0;
            if_ack   <= 1'b0;
            d_ack    <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state   <= BUSY_D;
                        m_en    <= 1'b1;
                        m_we    <= bus.d_we;
                        m_sel   <= bus.d_sel;
                        m_addr  <= bus.d_addr;
                        m_wdata <= bus.d_wdata;
                        last_d  <= 1'b1;
                    end else if (bus.if_req) begin
                        state   <= BUSY_I;
                        m_en    <= 1'b1;
                        m_we    <= 1'b0;
                        m_sel   <= '1;
                        m_addr  <= bus.if_addr;
                        m_wdata <= '0;
                        last_d  <= 1'b0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    // A timeout returns zero data; a same-cycle m_ready takes precedence.
                    if (bus.m_ready || timeout_hit) begin
                        state <= ACK;
                        m_en  <= 1'b0;
                        m_we  <= 1'b0;
                        m_sel <= '0;
                        if (state == BUSY_D) begin
                            d_ack   <= 1'b1;
                            d_rdata <= bus.m_ready ? bus.m_rdata : '0;
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= bus.m_ready ? bus.m_rdata : '0;
                        end
                    end
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.m_en         = m_en;
    assign bus.m_we         = m_we;
    assign bus.m_sel        = m_sel;
    assign bus.m_addr       = m_addr;
    assign bus.m_wdata      = m_wdata;
    assign bus.if_rdata     = if_rdata;
    assign bus.d_rdata      = d_rdata;
    assign bus.if_ack       = if_ack;
    assign bus.d_ack        = d_ack;
    assign bus.bus_err      = bus_err;
    assign bus.stallreq_if  = bus.if_req & ~if_ack;
    assign bus.stallreq_mem = bus.d_req & ~d_ack;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected acks, a monitor pops and compares.
// The memory model returns addr ^ 32'h24010045 after mem_wait wait cycles.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   mem_wait = 0;
    int   mem_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic push(input bit is_d, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.is_d  = is_d;
        e.rdata = rdata;
        e.err   = err;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input string name, input bit is_d, input int limit, output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!(is_d ? bus.d_ack : bus.if_ack) && lat < limit);
        check({name, "_ack_seen"}, is_d ? bus.d_ack : bus.if_ack, 1);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    // Memory model
    initial begin
        bus.m_ready = 1'b0;
        bus.m_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!resetn || !bus.m_en) begin
                bus.m_ready = 1'b0;
                mem_cnt     = 0;
            end else if (!bus.m_ready) begin
                if (mem_cnt >= mem_wait) begin
                    bus.m_ready = 1'b1;
                    bus.m_rdata = bus.m_addr ^ 32'h2401_0045;
                    mem_cnt     = 0;
                end else begin
                    mem_cnt++;
                end
            end
        end
    end

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.if_ack || bus.d_ack) begin
                check("dual_ack", {31'd0, bus.if_ack & bus.d_ack}, 0);
                if (sb.size() == 0) begin
                    check("unexpected_ack", {30'd0, bus.d_ack, bus.if_ack}, 0);
                end else begin
                    e = sb.pop_front();
                    check("ack_port", {31'd0, bus.d_ack}, {31'd0, e.is_d});
                    check("ack_rdata", e.is_d ? bus.d_rdata : bus.if_rdata, e.rdata);
                    check("ack_bus_err", {31'd0, bus.bus_err}, {31'd0, e.err});
                end
            end else if (bus.bus_err !== 1'b0) begin
                check("bus_err_without_ack", {31'd0, bus.bus_err}, 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          grant_cyc[4];
        logic [31:0] grant_addr[4];
        logic [31:0] exp_addr[4];
        int          ng;
        int          na;
        int          t;
        bit          prev_en;
        bit          any_ack;
        bit          any_err;

        resetn      = 1'b0;
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_sel   = '0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        tick();
        tick();

        // Reset state
        check("rst_m_en", bus.m_en, 0);
        check("rst_m_we", bus.m_we, 0);
        check("rst_m_sel", bus.m_sel, 0);
        check("rst_m_addr", bus.m_addr, 0);
        check("rst_m_wdata", bus.m_wdata, 0);
        check("rst_if_ack", bus.if_ack, 0);
        check("rst_d_ack", bus.d_ack, 0);
        check("rst_if_rdata", bus.if_rdata, 0);
        check("rst_d_rdata", bus.d_rdata, 0);
        check("rst_bus_err", bus.bus_err, 0);
        resetn = 1'b1;
        tick();

        // Fetch read, zero wait
        mem_wait    = 0;
        bus.if_addr = 32'h40;
        bus.if_req  = 1'b1;
        push(1'b0, 32'h2401_0005, 1'b0);
        #1;
        check("fetch_stall_c0", bus.stallreq_if, 1);
        tick();
        check("fetch_m_en_c1", bus.m_en, 1);
        check("fetch_m_addr_c1", bus.m_addr, 32'h40);
        check("fetch_m_we_c1", bus.m_we, 0);
        check("fetch_m_sel_c1", bus.m_sel, 4'hF);
        check("fetch_stall_c1", bus.stallreq_if, 1);
        tick();
        check("fetch_ack_c2", bus.if_ack, 1);
        check("fetch_stall_c2", bus.stallreq_if, 0);
        bus.if_req = 1'b0;
        tick();
        tick();

        // Data write with 3 wait cycles
        mem_wait    = 3;
        bus.d_we    = 1'b1;
        bus.d_sel   = 4'b0011;
        bus.d_addr  = 32'h100;
        bus.d_wdata = 32'hABCD_1234;
        bus.d_req   = 1'b1;
        push(1'b1, 32'h2401_0145, 1'b0);
        lat = 0;
        do begin
            tick();
            lat++;
            if (!bus.d_ack) begin
                check("wr_m_en", bus.m_en, 1);
                check("wr_m_we", bus.m_we, 1);
                check("wr_m_sel", bus.m_sel, 4'b0011);
                check("wr_m_addr", bus.m_addr, 32'h100);
                check("wr_m_wdata", bus.m_wdata, 32'hABCD_1234);
                check("wr_stall", bus.stallreq_mem, 1);
            end
        end while (!bus.d_ack && lat < 20);
        check("wr_ack", bus.d_ack, 1);
        check("wr_latency", lat, 5);
        check("wr_stall_at_ack", bus.stallreq_mem, 0);
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        tick();
        tick();

        // Contention from reset: D, I, D, I with 3-cycle grant spacing
        do_reset();
        mem_wait    = 0;
        bus.if_addr = 32'h80;
        bus.d_sel   = 4'hF;
        bus.d_addr  = 32'h200;
        bus.if_req  = 1'b1;
        bus.d_req   = 1'b1;
        push(1'b1, 32'h2401_0245, 1'b0);
        push(1'b0, 32'h2401_00C5, 1'b0);
        push(1'b1, 32'h2401_0245, 1'b0);
        push(1'b0, 32'h2401_00C5, 1'b0);
        exp_addr[0] = 32'h200;
        exp_addr[1] = 32'h80;
        exp_addr[2] = 32'h200;
        exp_addr[3] = 32'h80;
        ng = 0;
        na = 0;
        t = 0;
        prev_en = 1'b0;
        while (na < 4 && t < 40) begin
            tick();
            t++;
            if (bus.m_en && !prev_en && ng < 4) begin
                grant_cyc[ng]  = t;
                grant_addr[ng] = bus.m_addr;
                if (ng == 0) check("cont_stall_if_waiting", bus.stallreq_if, 1);
                ng++;
            end
            prev_en = bus.m_en;
            if (bus.if_ack || bus.d_ack) na++;
        end
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        check("cont_acks", na, 4);
        check("cont_grants", ng, 4);
        for (int i = 0; i < ng; i++) check("cont_grant_addr", grant_addr[i], exp_addr[i]);
        for (int i = 1; i < ng; i++) check("cont_spacing", grant_cyc[i] - grant_cyc[i-1], 3);
        tick();
        tick();

        // Reset while BUSY_D, then the still-pending request is served again
        mem_wait   = 1000;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h300;
        bus.d_req  = 1'b1;
        t = 0;
        do begin
            tick();
            t++;
        end while (!bus.m_en && t < 5);
        check("rstmid_busy", bus.m_en, 1);
        tick();
        resetn = 1'b0;
        #1;
        check("rstmid_m_en", bus.m_en, 0);
        check("rstmid_d_ack", bus.d_ack, 0);
        check("rstmid_m_addr", bus.m_addr, 0);
        check("rstmid_stall", bus.stallreq_mem, 1);
        tick();
        mem_wait = 0;
        push(1'b1, 32'h2401_0345, 1'b0);
        resetn = 1'b1;
        wait_ack("rstmid_retry", 1'b1, 10, lat);
        check("rstmid_retry_latency", lat, 2);
        bus.d_req = 1'b0;
        tick();
        tick();

`ifdef MEMARB_TIMEOUT_EN
        // Timeout after 4 wait cycles
        mem_wait   = 1000;
        bus.d_addr = 32'h400;
        bus.d_req  = 1'b1;
        push(1'b1, 32'h0, 1'b1);
        wait_ack("timeout", 1'b1, 20, lat);
        check("timeout_latency", lat, 5);
        check("timeout_m_en", bus.m_en, 0);
        bus.d_req = 1'b0;
        tick();
        tick();

        // m_ready on the limit cycle wins
        mem_wait  = 3;
        bus.d_req = 1'b1;
        push(1'b1, 32'h2401_0445, 1'b0);
        wait_ack("limit_ready", 1'b1, 20, lat);
        check("limit_ready_latency", lat, 5);
        bus.d_req = 1'b0;
        tick();
        tick();
`else
        // Without the timeout the access waits indefinitely
        mem_wait   = 1000;
        bus.d_addr = 32'h400;
        bus.d_req  = 1'b1;
        any_ack = 1'b0;
        any_err = 1'b0;
        for (int i = 0; i < 101; i++) begin
            tick();
            any_ack |= bus.d_ack;
            any_err |= bus.bus_err;
        end
        check("noto_still_busy", bus.m_en, 1);
        check("noto_no_ack", any_ack, 0);
        check("noto_no_bus_err", any_err, 0);
        check("noto_stall", bus.stallreq_mem, 1);
        bus.d_req = 1'b0;
        do_reset();
        tick();
`endif

        tick();
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
